// File: rtl/eth_seq.sv
// Frame sequencer between host logic and the Ethernet controller: tx/rx
// four-phase handshakes, quiescent-point mode changes and MDIO poll strobes.
module eth_seq #(
  parameter int POLL_DIV = 50000,
  parameter int TX_TMO   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_din,
  output logic        cfg_busy,
  input  logic        tx_go,
  input  logic [10:0] tx_len,
  output logic        tx_busy,
  output logic        tx_end,
  output logic        tx_err,
  output logic        rx_avail,
  output logic [10:0] rx_len,
  input  logic        rx_rel,
  output logic        txrdy,
  output logic [10:0] txcntb,
  input  logic        txdone,
  input  logic        rxrdy,
  input  logic [10:0] rxcntb,
  output logic        rxdone,
  output logic [4:0]  lbmode,
  output logic        md_evt,
  input  logic [7:0]  md_status,
  output logic        link,
  output logic        gbit
);

  localparam int PW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TX_TMO);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [PW-1:0] POLL_PRE  = PW'(POLL_DIV - 2);
  localparam logic [PW-1:0] POLL_ONE  = PW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TX_TMO - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_REL = 2'd2, T_ABORT = 2'd3} tx_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_HOLD = 2'd1, R_ACK = 2'd2} rx_state_t;

  tx_state_t tx_state_r, tx_next_s;
  rx_state_t rx_state_r, rx_next_s;
  logic          txdone_meta_r, txdone_sync_r, rxrdy_meta_r, rxrdy_sync_r;
  logic [TW-1:0] tx_timer_r;
  logic          tx_start_s, link_ok_s, tx_end_s, tx_err_s;
  logic          txrdy_r, tx_busy_r, tx_end_r, tx_err_r;
  logic [10:0]   txcntb_r, rx_len_r;
  logic          rx_avail_r, rxdone_r;
  logic [4:0]    cfg_pend_r, lbmode_r;
  logic          cfg_busy_r;
  logic [PW-1:0] poll_cnt_r;
  logic          md_evt_r, link_r, gbit_r;

  assign tx_start_s = (tx_state_r == T_IDLE) && tx_go && !cfg_busy_r;
  assign link_ok_s  = link_r || lbmode_r[1];

  // Two-flop synchronizers for the controller's asynchronous handshake lines
  always_ff @(posedge clk) begin
    if (rst) begin
      txdone_meta_r <= 1'b0;
      txdone_sync_r <= 1'b0;
      rxrdy_meta_r  <= 1'b0;
      rxrdy_sync_r  <= 1'b0;
    end else begin
      txdone_meta_r <= txdone;
      txdone_sync_r <= txdone_meta_r;
      rxrdy_meta_r  <= rxrdy;
      rxrdy_sync_r  <= rxrdy_meta_r;
    end
  end

  // FSM state registers and the txrdy timeout timer
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= T_IDLE;
      rx_state_r <= R_IDLE;
      tx_timer_r <= '0;
    end else begin
      tx_state_r <= tx_next_s;
      rx_state_r <= rx_next_s;
      if ((tx_state_r == T_REQ) && (tx_next_s == T_REQ)) tx_timer_r <= tx_timer_r + TMR_ONE;
      else tx_timer_r <= '0;
    end
  end

  // Next-state logic; a returning txdone wins over a simultaneous timeout
  always_comb begin
    tx_next_s = tx_state_r;
    case (tx_state_r)
      T_IDLE:  if (tx_start_s && link_ok_s) tx_next_s = T_REQ; else tx_next_s = T_IDLE;
      T_REQ: begin
        if (txdone_sync_r) tx_next_s = T_REL;
        else if (tx_timer_r == TMO_LAST) tx_next_s = T_ABORT;
        else tx_next_s = T_REQ;
      end
      T_REL:   if (!txdone_sync_r) tx_next_s = T_IDLE; else tx_next_s = T_REL;
      T_ABORT: if (!txdone_sync_r) tx_next_s = T_IDLE; else tx_next_s = T_ABORT;
      default: tx_next_s = T_IDLE;
    endcase
    rx_next_s = rx_state_r;
    case (rx_state_r)
      R_IDLE:  if (rxrdy_sync_r && (lbmode_r[0] || lbmode_r[1])) rx_next_s = R_HOLD; else rx_next_s = R_IDLE;
      R_HOLD:  if (rx_rel) rx_next_s = R_ACK; else rx_next_s = R_HOLD;
      R_ACK:   if (!rxrdy_sync_r) rx_next_s = R_IDLE; else rx_next_s = R_ACK;
      default: rx_next_s = R_IDLE;
    endcase
  end

  // Pulse outputs derived from the current state and transition
  always_comb begin
    tx_end_s = 1'b0;
    tx_err_s = 1'b0;
    case (tx_state_r)
      T_IDLE:  tx_err_s = tx_start_s && !link_ok_s;
      T_REQ:   tx_err_s = (tx_next_s == T_ABORT);
      T_REL:   tx_end_s = !txdone_sync_r;
      T_ABORT: tx_end_s = 1'b0;
      default: tx_err_s = 1'b0;
    endcase
  end

  // Output registers follow next state so levels track the FSMs with no extra lag
  always_ff @(posedge clk) begin
    if (rst) begin
      txrdy_r    <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_end_r   <= 1'b0;
      tx_err_r   <= 1'b0;
      txcntb_r   <= 11'd0;
      rx_avail_r <= 1'b0;
      rxdone_r   <= 1'b0;
      rx_len_r   <= 11'd0;
    end else begin
      txrdy_r    <= (tx_next_s == T_REQ);
      tx_busy_r  <= (tx_next_s != T_IDLE);
      tx_end_r   <= tx_end_s;
      tx_err_r   <= tx_err_s;
      rx_avail_r <= (rx_next_s == R_HOLD);
      rxdone_r   <= (rx_next_s == R_ACK);
      if ((tx_state_r == T_IDLE) && (tx_next_s == T_REQ)) txcntb_r <= tx_len;
      if ((rx_state_r == R_IDLE) && (rx_next_s == R_HOLD)) rx_len_r <= rxcntb;
    end
  end

  // Mode changes wait until both channels are idle; a fresh write defers the apply
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pend_r <= 5'd0;
      cfg_busy_r <= 1'b0;
      lbmode_r   <= 5'd0;
    end else if (cfg_wr) begin
      cfg_pend_r <= cfg_din;
      cfg_busy_r <= 1'b1;
    end else if (cfg_busy_r && (tx_state_r == T_IDLE) && (rx_state_r == R_IDLE)) begin
      lbmode_r   <= cfg_pend_r;
      cfg_busy_r <= 1'b0;
    end
  end

  // Poll divider and registered link status
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_r <= '0;
      md_evt_r   <= 1'b0;
      link_r     <= 1'b0;
      gbit_r     <= 1'b0;
    end else begin
      if (poll_cnt_r == POLL_LAST) poll_cnt_r <= '0;
      else poll_cnt_r <= poll_cnt_r + POLL_ONE;
      md_evt_r <= (poll_cnt_r == POLL_PRE);
      link_r   <= md_status[0];
      gbit_r   <= (md_status[6:5] == 2'b10) && md_status[0];
    end
  end

  assign cfg_busy = cfg_busy_r;
  assign tx_busy  = tx_busy_r;
  assign tx_end   = tx_end_r;
  assign tx_err   = tx_err_r;
  assign rx_avail = rx_avail_r;
  assign rx_len   = rx_len_r;
  assign txrdy    = txrdy_r;
  assign txcntb   = txcntb_r;
  assign rxdone   = rxdone_r;
  assign lbmode   = lbmode_r;
  assign md_evt   = md_evt_r;
  assign link     = link_r;
  assign gbit     = gbit_r;

endmodule

// File: tb/tb_eth_seq.sv
// Directed self-checking bench for eth_seq with short poll and timeout settings.
module tb_eth_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [4:0]  cfg_din;
  logic        cfg_busy;
  logic        tx_go;
  logic [10:0] tx_len;
  logic        tx_busy, tx_end, tx_err;
  logic        rx_avail;
  logic [10:0] rx_len;
  logic        rx_rel;
  logic        txrdy;
  logic [10:0] txcntb;
  logic        txdone, rxrdy;
  logic [10:0] rxcntb;
  logic        rxdone;
  logic [4:0]  lbmode;
  logic        md_evt;
  logic [7:0]  md_status;
  logic        link, gbit;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int end_pulses = 0;
  int base_err, base_end, cnt;

  always #5 clk = ~clk;

  eth_seq #(.POLL_DIV(5), .TX_TMO(16)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_din(cfg_din), .cfg_busy(cfg_busy),
    .tx_go(tx_go), .tx_len(tx_len), .tx_busy(tx_busy), .tx_end(tx_end), .tx_err(tx_err),
    .rx_avail(rx_avail), .rx_len(rx_len), .rx_rel(rx_rel), .txrdy(txrdy), .txcntb(txcntb),
    .txdone(txdone), .rxrdy(rxrdy), .rxcntb(rxcntb), .rxdone(rxdone), .lbmode(lbmode),
    .md_evt(md_evt), .md_status(md_status), .link(link), .gbit(gbit)
  );

  always @(negedge clk) begin
    if (tx_err) err_pulses <= err_pulses + 1;
    if (tx_end) end_pulses <= end_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_cfg(input logic [4:0] v);
    cfg_din = v;
    cfg_wr  = 1'b1;
    tick();
    cfg_wr  = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_din = 5'd0; tx_go = 1'b0; tx_len = 11'd0;
    rx_rel = 1'b0; txdone = 1'b0; rxrdy = 1'b0; rxcntb = 11'd0; md_status = 8'h00;
    ticks(3);
    check("rst_txrdy", 32'(txrdy), 32'd0);
    check("rst_rxdone", 32'(rxdone), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_end", 32'(tx_end), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_rx_avail", 32'(rx_avail), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_md_evt", 32'(md_evt), 32'd0);
    check("rst_link", 32'(link), 32'd0);
    check("rst_gbit", 32'(gbit), 32'd0);
    check("rst_txcntb", 32'(txcntb), 32'd0);
    check("rst_rx_len", 32'(rx_len), 32'd0);
    check("rst_lbmode", 32'(lbmode), 32'd0);

    // poll spacing from reset release, then a reset in mid-count
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      check("poll", 32'(md_evt), (k % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("poll_rst", 32'(md_evt), (k % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end

    md_status = 8'h41; tick();
    check("link_41", 32'(link), 32'd1);
    check("gbit_41", 32'(gbit), 32'd1);
    md_status = 8'h40; tick();
    check("link_40", 32'(link), 32'd0);
    check("gbit_40", 32'(gbit), 32'd0);
    md_status = 8'h21; tick();
    check("link_21", 32'(link), 32'd1);
    check("gbit_21", 32'(gbit), 32'd0);
    md_status = 8'h41; tick();

    // normal transmit
    base_err = err_pulses; base_end = end_pulses;
    tx_len = 11'd64; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("tx_txrdy_up", 32'(txrdy), 32'd1);
    check("tx_busy_up", 32'(tx_busy), 32'd1);
    check("tx_txcntb", 32'(txcntb), 32'd64);
    ticks(10);
    txdone = 1'b1;
    ticks(2);
    check("tx_txrdy_hold", 32'(txrdy), 32'd1);
    tick();
    check("tx_txrdy_drop", 32'(txrdy), 32'd0);
    ticks(2);
    txdone = 1'b0;
    ticks(2);
    check("tx_end_early", 32'(tx_end), 32'd0);
    tick();
    check("tx_end_pulse", 32'(tx_end), 32'd1);
    check("tx_busy_done", 32'(tx_busy), 32'd0);
    tick();
    check("tx_end_width", 32'(tx_end), 32'd0);
    check("tx_end_count", 32'(end_pulses - base_end), 32'd1);
    check("tx_no_err", 32'(err_pulses - base_err), 32'd0);

    // timeout: txrdy held for exactly TX_TMO cycles
    base_err = err_pulses;
    tx_len = 11'd5; tx_go = 1'b1; tick(); tx_go = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (txrdy) begin
        cnt++;
        tick();
      end
    end
    check("tmo_txrdy_cycles", 32'(cnt), 32'd16);
    check("tmo_err_pulse", 32'(tx_err), 32'd1);
    tick();
    check("tmo_busy_clear", 32'(tx_busy), 32'd0);
    check("tmo_err_width", 32'(tx_err), 32'd0);
    check("tmo_err_count", 32'(err_pulses - base_err), 32'd1);

    // link down without loopback
    md_status = 8'h00; ticks(2);
    check("ld_link", 32'(link), 32'd0);
    base_err = err_pulses;
    tx_len = 11'd20; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("ld_err", 32'(tx_err), 32'd1);
    check("ld_txrdy", 32'(txrdy), 32'd0);
    check("ld_busy", 32'(tx_busy), 32'd0);
    ticks(3);
    check("ld_txrdy_late", 32'(txrdy), 32'd0);
    check("ld_err_count", 32'(err_pulses - base_err), 32'd1);
    check("ld_txcntb_kept", 32'(txcntb), 32'd5);

    // link down with internal loopback proceeds
    cfg_din = 5'b00010; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
    check("lp_cfg_busy", 32'(cfg_busy), 32'd1);
    tick();
    check("lp_cfg_clear", 32'(cfg_busy), 32'd0);
    check("lp_lbmode", 32'(lbmode), 32'd2);
    tx_len = 11'd100; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("lp_txrdy", 32'(txrdy), 32'd1);
    check("lp_txcntb", 32'(txcntb), 32'd100);
    txdone = 1'b1; ticks(3);
    check("lp_txrdy_drop", 32'(txrdy), 32'd0);
    txdone = 1'b0; ticks(3);
    check("lp_tx_end", 32'(tx_end), 32'd1);
    tick();

    // receive with rx enabled
    write_cfg(5'b00001);
    check("rx_lbmode", 32'(lbmode), 32'd1);
    rx_rel = 1'b1; tick(); rx_rel = 1'b0;
    check("rx_rel_ignored", 32'(rxdone), 32'd0);
    rxcntb = 11'd1518; rxrdy = 1'b1;
    ticks(2);
    check("rx_avail_early", 32'(rx_avail), 32'd0);
    tick();
    check("rx_avail", 32'(rx_avail), 32'd1);
    check("rx_len", 32'(rx_len), 32'd1518);
    ticks(2);
    rx_rel = 1'b1; tick(); rx_rel = 1'b0;
    check("rx_rxdone", 32'(rxdone), 32'd1);
    check("rx_avail_clr", 32'(rx_avail), 32'd0);
    ticks(3);
    check("rx_rxdone_hold", 32'(rxdone), 32'd1);
    rxrdy = 1'b0;
    ticks(2);
    check("rx_rxdone_late", 32'(rxdone), 32'd1);
    tick();
    check("rx_rxdone_drop", 32'(rxdone), 32'd0);

    // receive disabled
    write_cfg(5'b00000);
    check("rxoff_lbmode", 32'(lbmode), 32'd0);
    rxcntb = 11'd99; rxrdy = 1'b1;
    ticks(6);
    check("rxoff_avail", 32'(rx_avail), 32'd0);
    check("rxoff_len_kept", 32'(rx_len), 32'd1518);
    rxrdy = 1'b0; ticks(3);

    // deferred config during an active frame
    md_status = 8'h41; ticks(2);
    tx_len = 11'd64; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("dc_txrdy", 32'(txrdy), 32'd1);
    cfg_din = 5'b00100; cfg_wr = 1'b1; tick();
    cfg_din = 5'b00011; tick(); cfg_wr = 1'b0;
    check("dc_busy", 32'(cfg_busy), 32'd1);
    check("dc_lbmode_held", 32'(lbmode), 32'd0);
    tx_len = 11'd9; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("dc_go_ignored", 32'(txcntb), 32'd64);
    txdone = 1'b1; ticks(3);
    check("dc_lbmode_rel", 32'(lbmode), 32'd0);
    check("dc_busy_rel", 32'(cfg_busy), 32'd1);
    txdone = 1'b0; ticks(3);
    check("dc_tx_end", 32'(tx_end), 32'd1);
    check("dc_busy_end", 32'(cfg_busy), 32'd1);
    check("dc_lbmode_end", 32'(lbmode), 32'd0);
    tx_len = 11'd7; tx_go = 1'b1; tick(); tx_go = 1'b0;
    check("dc_lbmode_applied", 32'(lbmode), 32'd3);
    check("dc_busy_clear", 32'(cfg_busy), 32'd0);
    check("dc_go_while_busy", 32'(txrdy), 32'd0);
    check("dc_tx_busy", 32'(tx_busy), 32'd0);
    tick();
    check("dc_txrdy_stays", 32'(txrdy), 32'd0);
    check("dc_txcntb_kept", 32'(txcntb), 32'd64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
